// File: rtl/wall_map.sv
`default_nettype none
// ============================================================================
// Module   : wall_map
// Purpose  : 64x44 playfield wall bitmap. It has a renderer read port and a
//            game query/destroy port, and it rebuilds the level after reset
//            or reload. Optional macro WALL_DESTRUCT_EN enables destroy
//            writes.
// Revision : 1.0  initial release
// ============================================================================
module wall_map #(
    parameter int COLS = 64,
    parameter int ROWS = 44
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_vga_request_x,
    input  logic [5:0] i_vga_request_y,
    input  logic       i_vga_busy,
    output logic       o_is_wall,
    input  logic       i_reload,
    output logic       o_init_done,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_write,
    input  logic [5:0] i_cmd_x,
    input  logic [5:0] i_cmd_y,
    output logic       o_cmd_ready,
    output logic       o_rsp_valid,
    output logic       o_rsp_is_wall,
    output logic [7:0] o_walls_destroyed
);

    localparam int c_DEPTH = COLS * ROWS;

`ifdef WALL_DESTRUCT_EN
    localparam logic c_DESTRUCT_EN = 1'b1;
`else
    localparam logic c_DESTRUCT_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [11:0] r_init_addr;
    logic        r_mem [0:c_DEPTH-1];
    logic        r_is_wall;
    logic        r_init_done;
    logic        r_rsp_valid;
    logic        r_rsp_is_wall;
    logic [7:0]  r_walls_destroyed;

    // Border cells plus 1x4 pillars on an 8x8 lattice.
    function automatic logic pattern_bit(input logic [11:0] addr);
        logic [5:0] x;
        logic [5:0] y;
        x = addr[5:0];
        y = addr[11:6];
        return (x == 6'd0) || (x == 6'(COLS - 1)) ||
               (y == 6'd0) || (y == 6'(ROWS - 1)) ||
               ((x[2:0] == 3'd4) && (y[2:0] >= 3'd2) && (y[2:0] <= 3'd5));
    endfunction

    logic [11:0] w_cmd_addr;
    logic        w_cmd_on_map;
    logic        w_cmd_old;
    logic        w_accept;
    logic        w_destroy_wr;
    logic        w_count_inc;
    logic [11:0] w_vga_addr;
    logic        w_vga_on_map;
    logic        w_mem_we;
    logic [11:0] w_mem_addr;
    logic        w_mem_din;

    assign w_cmd_addr   = {i_cmd_y, i_cmd_x};
    assign w_cmd_on_map = (i_cmd_y < 6'(ROWS));
    assign w_cmd_old    = w_cmd_on_map ? r_mem[w_cmd_addr] : 1'b1;
    assign o_cmd_ready  = (r_state == ST_RUN) && !i_vga_busy && !i_reload;
    assign w_accept     = i_cmd_valid && o_cmd_ready;
    assign w_destroy_wr = w_accept && i_cmd_write && w_cmd_on_map && c_DESTRUCT_EN;
    assign w_count_inc  = w_destroy_wr && w_cmd_old && (r_walls_destroyed != 8'hFF);

    assign w_vga_addr   = {i_vga_request_y, i_vga_request_x};
    assign w_vga_on_map = (i_vga_request_y < 6'(ROWS));

    // Init sweep and destroy writes are exclusive by state.
    assign w_mem_we   = (r_state == ST_INIT) || w_destroy_wr;
    assign w_mem_addr = (r_state == ST_INIT) ? r_init_addr : w_cmd_addr;
    assign w_mem_din  = (r_state == ST_INIT) ? pattern_bit(r_init_addr) : 1'b0;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_wall <= 1'b0;
        end else if (r_state != ST_RUN) begin
            r_is_wall <= 1'b0;
        end else begin
            r_is_wall <= w_vga_on_map ? r_mem[w_vga_addr] : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_INIT;
            r_init_addr       <= 12'd0;
            r_init_done       <= 1'b0;
            r_rsp_valid       <= 1'b0;
            r_rsp_is_wall     <= 1'b0;
            r_walls_destroyed <= 8'd0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_is_wall <= w_cmd_old;
            end
            if (i_reload) begin
                r_state           <= ST_INIT;
                r_init_addr       <= 12'd0;
                r_init_done       <= 1'b0;
                r_walls_destroyed <= 8'd0;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        if (r_init_addr == 12'(c_DEPTH - 1)) begin
                            r_state     <= ST_RUN;
                            r_init_done <= 1'b1;
                            r_init_addr <= 12'd0;
                        end else begin
                            r_init_addr <= r_init_addr + 12'd1;
                        end
                    end
                    ST_RUN: begin
                        if (w_count_inc) begin
                            r_walls_destroyed <= r_walls_destroyed + 8'd1;
                        end
                    end
                    default: r_state <= ST_INIT;
                endcase
            end
        end
    end

    assign o_is_wall         = r_is_wall;
    assign o_init_done       = r_init_done;
    assign o_rsp_valid       = r_rsp_valid;
    assign o_rsp_is_wall     = r_rsp_is_wall;
    assign o_walls_destroyed = r_walls_destroyed;

endmodule
`default_nettype wire

// File: tb/tb_wall_map.sv
`default_nettype none
// ============================================================================
// Module   : tb_wall_map
// Purpose  : Scoreboard bench for wall_map; responds to WALL_DESTRUCT_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_wall_map;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] vga_x = '0;
    logic [5:0] vga_y = '0;
    logic       vga_busy = 1'b0;
    logic       is_wall;
    logic       reload = 1'b0;
    logic       init_done;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [5:0] cmd_x = '0;
    logic [5:0] cmd_y = '0;
    logic       cmd_ready;
    logic       rsp_valid;
    logic       rsp_is_wall;
    logic [7:0] walls_destroyed;

    wall_map #(.COLS(64), .ROWS(44)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_vga_request_x   (vga_x),
        .i_vga_request_y   (vga_y),
        .i_vga_busy        (vga_busy),
        .o_is_wall         (is_wall),
        .i_reload          (reload),
        .o_init_done       (init_done),
        .i_cmd_valid       (cmd_valid),
        .i_cmd_write       (cmd_write),
        .i_cmd_x           (cmd_x),
        .i_cmd_y           (cmd_y),
        .o_cmd_ready       (cmd_ready),
        .o_rsp_valid       (rsp_valid),
        .o_rsp_is_wall     (rsp_is_wall),
        .o_walls_destroyed (walls_destroyed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic val;
        int   cyc;
        int   x;
        int   y;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_now = 0;

    always @(posedge clk) cyc_now++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_now);
        end
    endtask

    // Response monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("rsp_is_wall(%0d,%0d)", e.x, e.y), int'(rsp_is_wall), int'(e.val));
                check($sformatf("rsp_cycle(%0d,%0d)", e.x, e.y), cyc_now, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    // with cmd_valid still high so commands can go back-to-back.
    task automatic send(input logic wr, input int x, input int y, input logic exp_bit);
        int   tries;
        exp_t e;
        tries     = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_x     = 6'(x);
        cmd_y     = 6'(y);
        #1;
        while (!cmd_ready && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", int'(cmd_ready), 1);
        end else begin
            e.val = exp_bit;
            e.cyc = cyc_now + 1;
            e.x   = x;
            e.y   = y;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   rc;
        logic rdy_seen;
        logic wall_seen;

        repeat (3) @(negedge clk);
        check("reset_is_wall", int'(is_wall), 0);
        check("reset_init_done", int'(init_done), 0);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_is_wall", int'(rsp_is_wall), 0);
        check("reset_walls_destroyed", int'(walls_destroyed), 0);
        check("reset_cmd_ready", int'(cmd_ready), 0);

        // Renderer points at a wall cell during init; it must read as 0.
        rst_n     = 1'b1;
        cyc       = 0;
        rdy_seen  = 1'b0;
        wall_seen = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (!init_done) begin
                if (cmd_ready) rdy_seen = 1'b1;
                if (is_wall)   wall_seen = 1'b1;
            end
        end while (!init_done && cyc < 4000);
        check("init_cycles", cyc, 2816);
        check("ready_during_init", int'(rdy_seen), 0);
        check("is_wall_during_init", int'(wall_seen), 0);
        check("ready_after_init", int'(cmd_ready), 1);

        send(1'b0, 0, 5, 1'b1);
        send(1'b0, 4, 3, 1'b1);
        send(1'b0, 5, 3, 1'b0);
        send(1'b0, 2, 2, 1'b0);
        send(1'b0, 61, 41, 1'b0);
        send(1'b0, 63, 20, 1'b1);
        send(1'b0, 3, 50, 1'b1);
        idle(2);

        vga_x = 6'd12; vga_y = 6'd10;
        @(negedge clk);
        check("vga(12,10)", int'(is_wall), 1);
        vga_x = 6'd13; vga_y = 6'd10;
        @(negedge clk);
        check("vga(13,10)", int'(is_wall), 0);
        vga_x = 6'd5; vga_y = 6'd50;
        @(negedge clk);
        check("vga(5,50)", int'(is_wall), 1);
        vga_x = 6'd20; vga_y = 6'd43;
        @(negedge clk);
        check("vga(20,43)", int'(is_wall), 1);

`ifdef WALL_DESTRUCT_EN
        vga_x = 6'd4; vga_y = 6'd2;
        send(1'b1, 4, 2, 1'b1);
        check("vga_read_before_write", int'(is_wall), 1);
        check("count_after_destroy", int'(walls_destroyed), 1);
        send(1'b0, 4, 2, 1'b0);
        check("vga_after_destroy", int'(is_wall), 0);
        send(1'b1, 4, 2, 1'b0);
        check("count_after_redestroy", int'(walls_destroyed), 1);
        send(1'b1, 0, 50, 1'b1);
        check("count_after_offmap", int'(walls_destroyed), 1);
        send(1'b1, 5, 5, 1'b0);
        check("count_after_empty", int'(walls_destroyed), 1);
        idle(2);
`else
        send(1'b1, 0, 0, 1'b1);
        send(1'b0, 0, 0, 1'b1);
        send(1'b1, 4, 2, 1'b1);
        send(1'b0, 4, 2, 1'b1);
        idle(1);
        check("count_no_destruct", int'(walls_destroyed), 0);
`endif

        vga_busy  = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_x     = 6'd5;
        cmd_y     = 6'd3;
        #1;
        check("ready_drops_with_busy", int'(cmd_ready), 0);
        repeat (5) @(negedge clk);
        vga_busy = 1'b0;
        send(1'b0, 5, 3, 1'b0);
        send(1'b0, 4, 3, 1'b1);
        vga_busy = 1'b1;
        idle(3);
        vga_busy = 1'b0;

        send(1'b1, 12, 10, 1'b1);
        idle(100);
        reload = 1'b1;
        #1;
        check("ready_during_reload", int'(cmd_ready), 0);
        @(negedge clk);
        reload = 1'b0;
        rc     = 1;
        check("reload_init_done", int'(init_done), 0);
        check("reload_count", int'(walls_destroyed), 0);
        do begin
            @(negedge clk);
            rc++;
        end while (!init_done && rc < 4000);
        // Counted in negedges from the reload pulse: one for the reload edge
        // plus the full sweep.
        check("reload_cycles", rc, 2817);
        send(1'b0, 4, 2, 1'b1);
        send(1'b0, 12, 10, 1'b1);
        send(1'b0, 13, 10, 1'b0);
        idle(3);

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
